// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback stage: opcodes, instruction
// field layout, FSM states and a small decode helper.
package alu_pkg;

  localparam int DW    = 16;
  localparam int NREGS = 8;
  localparam int IW    = 16;
  localparam int RW    = 3;
  localparam int IMM_W = 9;

  localparam int OP_LSB   = 12;
  localparam int RD_LSB   = 9;
  localparam int RS1_LSB  = 6;
  localparam int RS2_LSB  = 3;
  localparam int FLAG_BIT = 2;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_HALT = 4'd14,
    OP_LDI  = 4'd15
  } op_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  typedef struct packed {
    logic [3:0]       op;
    logic [RW-1:0]    rd;
    logic [RW-1:0]    rs1;
    logic [RW-1:0]    rs2;
    logic             flag;
    logic [IMM_W-1:0] imm;
  } instr_t;

  function automatic instr_t decode_instr(input logic [IW-1:0] w);
    instr_t d;
    d.op   = w[OP_LSB +: 4];
    d.rd   = w[RD_LSB +: RW];
    d.rs1  = w[RS1_LSB +: RW];
    d.rs2  = w[RS2_LSB +: RW];
    d.flag = w[FLAG_BIT];
    d.imm  = w[IMM_W-1:0];
    return d;
  endfunction

  function automatic logic op_is_alu(input logic [3:0] op);
    return op <= 4'(OP_NOT);
  endfunction

endpackage

// File: rtl/regfile_8x16.sv
// Register file: two combinational read ports, one synchronous write port,
// r0 reads as zero and is never written.
module regfile_8x16 #(
  parameter  int NREGS = 8,
  parameter  int DW    = 16,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr1_i,
  input  logic [AW-1:0] raddr2_i,
  output logic [DW-1:0] rdata1_o,
  output logic [DW-1:0] rdata2_o
);

  logic [NREGS-1:0][DW-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : mem_q[raddr2_i];

endmodule

// File: rtl/alu_issue_wb.sv
// Issue/writeback stage in front of the 16-bit combinational ALU: one-cycle
// issue-to-writeback pipeline with RAW forwarding, HALT/resume and error flag.
module alu_issue_wb #(
  parameter int NREGS = 8,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  input  logic          resume,
  output logic [3:0]    op_code,
  output logic [DW-1:0] input1,
  output logic [DW-1:0] input2,
  output logic          cin,
  output logic          bin,
  input  logic [DW-1:0] rslt,
  output logic          wb_valid,
  output logic [2:0]    wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          err,
  output logic          halted,
  output logic [15:0]   retire_cnt
);

  import alu_pkg::*;

  state_e state_q, state_d;
  instr_t dec;

  logic          xfer, is_alu, is_ldi, is_halt, is_ill;
  logic          fwd1, fwd2;
  logic [DW-1:0] rf_rd1, rf_rd2, opnd1, opnd2;

  logic [3:0]       op_code_q, op_code_d;
  logic [DW-1:0]    in1_q, in1_d, in2_q, in2_d;
  logic             cin_q, cin_d, bin_q, bin_d;
  logic             s2_vld_q, s2_vld_d, s2_ldi_q, s2_ldi_d;
  logic [RW-1:0]    s2_rd_q, s2_rd_d;
  logic [IMM_W-1:0] s2_imm_q, s2_imm_d;
  logic             err_q, err_d;
  logic [15:0]      retire_q, retire_d;

  assign dec     = decode_instr(instr);
  assign xfer    = instr_valid && instr_ready;
  assign is_alu  = op_is_alu(dec.op);
  assign is_ldi  = (dec.op == OP_LDI);
  assign is_halt = (dec.op == OP_HALT);
  assign is_ill  = !is_alu && !is_ldi && !is_halt;

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (xfer && is_halt) state_d = ST_HALTED;
      ST_HALTED: if (resume)          state_d = ST_RUN;
      default:                        state_d = ST_RUN;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == ST_RUN) && !rst;
    halted      = (state_q == ST_HALTED);
  end

  // ---- writeback (stage 2) ----
  // A reset landing on a writeback cycle must not show or commit that write.
  assign wb_valid = s2_vld_q && !rst;
  assign wb_addr  = s2_rd_q;
  assign wb_data  = s2_ldi_q ? {{(DW-IMM_W){1'b0}}, s2_imm_q} : rslt;

  regfile_8x16 #(.NREGS(NREGS), .DW(DW)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_valid),
    .waddr_i  (s2_rd_q),
    .wdata_i  (wb_data),
    .raddr1_i (dec.rs1),
    .raddr2_i (dec.rs2),
    .rdata1_o (rf_rd1),
    .rdata2_o (rf_rd2)
  );

  // The stage-2 value is not in the register file until the end of this cycle.
  assign fwd1  = s2_vld_q && (dec.rs1 != '0) && (dec.rs1 == s2_rd_q);
  assign fwd2  = s2_vld_q && (dec.rs2 != '0) && (dec.rs2 == s2_rd_q);
  assign opnd1 = fwd1 ? wb_data : rf_rd1;
  assign opnd2 = fwd2 ? wb_data : rf_rd2;

  // ---- issue (stage 1) ----
  always_comb begin
    op_code_d = op_code_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    cin_d     = cin_q;
    bin_d     = bin_q;
    if (xfer && is_alu) begin
      op_code_d = dec.op;
      in1_d     = opnd1;
      in2_d     = opnd2;
      cin_d     = (dec.op == OP_ADD) && dec.flag;
      bin_d     = (dec.op == OP_SUB) && dec.flag;
    end
    s2_vld_d = xfer && (is_alu || is_ldi);
    s2_ldi_d = is_ldi;
    s2_rd_d  = dec.rd;
    s2_imm_d = dec.imm;
    err_d    = err_q || (xfer && is_ill);
    retire_d = retire_q + {15'd0, wb_valid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_code_q <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      cin_q     <= 1'b0;
      bin_q     <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_ldi_q  <= 1'b0;
      s2_rd_q   <= '0;
      s2_imm_q  <= '0;
      err_q     <= 1'b0;
      retire_q  <= '0;
    end else begin
      op_code_q <= op_code_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      cin_q     <= cin_d;
      bin_q     <= bin_d;
      s2_vld_q  <= s2_vld_d;
      s2_ldi_q  <= s2_ldi_d;
      s2_rd_q   <= s2_rd_d;
      s2_imm_q  <= s2_imm_d;
      err_q     <= err_d;
      retire_q  <= retire_d;
    end
  end

  assign op_code    = op_code_q;
  assign input1     = in1_q;
  assign input2     = in2_q;
  assign cin        = cin_q;
  assign bin        = bin_q;
  assign err        = err_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: behavioural ALU, vector table plus hand-written
// HALT and reset sequences, writebacks checked against a due-cycle queue.
module tb_alu_issue_wb;

  logic        clk = 1'b0;
  logic        rst, instr_valid, instr_ready, resume;
  logic [15:0] instr, input1, input2, rslt, wb_data, retire_cnt;
  logic [3:0]  op_code;
  logic        cin, bin, wb_valid, err, halted;
  logic [2:0]  wb_addr;

  always #5 clk = ~clk;

  alu_issue_wb #(.NREGS(8), .DW(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .resume(resume), .op_code(op_code), .input1(input1),
    .input2(input2), .cin(cin), .bin(bin), .rslt(rslt), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .err(err), .halted(halted),
    .retire_cnt(retire_cnt)
  );

  always_comb begin
    case (op_code)
      4'd0:    rslt = input1 + input2 + {15'd0, cin};
      4'd1:    rslt = input1 - input2 - {15'd0, bin};
      4'd2:    rslt = input1 & input2;
      4'd3:    rslt = input1 | input2;
      4'd4:    rslt = input1 ^ input2;
      4'd5:    rslt = ~input1;
      default: rslt = 16'd0;
    endcase
  end

  typedef struct {
    int          due;
    logic [2:0]  a;
    logic [15:0] d;
    bit          alu;
    logic [3:0]  op;
    logic [15:0] i1, i2;
    bit          ci, bi;
  } exp_t;

  typedef struct {
    logic [15:0] w;
    bit          wb;
    logic [2:0]  a;
    logic [15:0] d;
    bit          alu;
    logic [3:0]  op;
    logic [15:0] i1, i2;
    bit          ci, bi;
  } vec_t;

  exp_t        q[$];
  vec_t        tbl[13];
  int          checks = 0, errors = 0, cyc = 0;
  bit          halted_m = 0, err_m = 0;
  logic [15:0] retire_m = '0;

  function automatic logic [15:0] enc(input int op, input int rd, input int rs1,
                                      input int rs2, input int f);
    return {op[3:0], rd[2:0], rs1[2:0], rs2[2:0], f[0], 2'b00};
  endfunction

  function automatic logic [15:0] ldi(input int rd, input int imm);
    return {4'hF, rd[2:0], imm[8:0]};
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", n, cyc, a, e);
    end
  endtask

  task automatic push(input logic [2:0] a, input logic [15:0] d, input bit alu,
                      input logic [3:0] op, input logic [15:0] i1,
                      input logic [15:0] i2, input bit ci, input bit bi);
    exp_t x;
    x.due = cyc + 1; x.a = a; x.d = d; x.alu = alu; x.op = op;
    x.i1 = i1; x.i2 = i2; x.ci = ci; x.bi = bi;
    q.push_back(x);
  endtask

  // One clock cycle: drive at negedge, check this cycle's outputs, advance model.
  task automatic step(input bit v, input logic [15:0] w, input bit res, input bit r);
    bit         xf, wb_seen;
    exp_t       x;
    logic [3:0] op;
    instr_valid = v; instr = w; resume = res; rst = r;
    #1;
    chk("instr_ready", 32'(instr_ready), 32'(!halted_m && !r));
    chk("halted", 32'(halted), 32'(halted_m));
    chk("err", 32'(err), 32'(err_m));
    chk("retire_cnt", 32'(retire_cnt), 32'(retire_m));
    wb_seen = 0;
    if (q.size() > 0 && q[0].due == cyc) begin
      x = q.pop_front();
      if (!r) begin
        wb_seen = 1;
        chk("wb_valid", 32'(wb_valid), 32'd1);
        chk("wb_addr", 32'(wb_addr), 32'(x.a));
        chk("wb_data", 32'(wb_data), 32'(x.d));
        if (x.alu) begin
          chk("op_code", 32'(op_code), 32'(x.op));
          chk("input1", 32'(input1), 32'(x.i1));
          chk("input2", 32'(input2), 32'(x.i2));
          chk("cin", 32'(cin), 32'(x.ci));
          chk("bin", 32'(bin), 32'(x.bi));
        end
      end else begin
        chk("wb_valid_rst", 32'(wb_valid), 32'd0);
      end
    end else begin
      chk("wb_valid_idle", 32'(wb_valid), 32'd0);
    end
    xf = v && !halted_m && !r;
    op = w[15:12];
    @(negedge clk);
    cyc++;
    if (r) begin
      halted_m = 0; err_m = 0; retire_m = '0; q.delete();
    end else begin
      if (wb_seen) retire_m++;
      if (xf && op >= 4'd6 && op <= 4'd13) err_m = 1;
      if (halted_m) begin
        if (res) halted_m = 0;
      end else if (xf && op == 4'd14) begin
        halted_m = 1;
      end
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_op_code"}, 32'(op_code), 32'd0);
    chk({tag, "_input1"}, 32'(input1), 32'd0);
    chk({tag, "_input2"}, 32'(input2), 32'd0);
    chk({tag, "_cin"}, 32'(cin), 32'd0);
    chk({tag, "_bin"}, 32'(bin), 32'd0);
    chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
    chk({tag, "_wb_addr"}, 32'(wb_addr), 32'd0);
    chk({tag, "_wb_data"}, 32'(wb_data), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_retire"}, 32'(retire_cnt), 32'd0);
  endtask

  initial begin
    //            instr                     wb a  data      alu op  in1       in2       ci bi
    tbl[0]  = '{ldi(1, 5),                  1, 1, 16'h0005, 0, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[1]  = '{ldi(2, 3),                  1, 2, 16'h0003, 0, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[2]  = '{enc(0, 3, 1, 2, 0),         1, 3, 16'h0008, 1, 0, 16'h0005, 16'h0003, 0, 0};
    tbl[3]  = '{enc(1, 4, 1, 2, 1),         1, 4, 16'h0001, 1, 1, 16'h0005, 16'h0003, 0, 1};
    tbl[4]  = '{enc(5, 5, 4, 0, 0),         1, 5, 16'hFFFE, 1, 5, 16'h0001, 16'h0000, 0, 0};
    tbl[5]  = '{enc(7, 1, 1, 1, 0),         0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[6]  = '{ldi(6, 9),                  1, 6, 16'h0009, 0, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[7]  = '{ldi(0, 9'h1FF),             1, 0, 16'h01FF, 0, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[8]  = '{enc(0, 7, 0, 0, 0),         1, 7, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0};
    tbl[9]  = '{enc(4, 1, 3, 5, 0),         1, 1, 16'hFFF6, 1, 4, 16'h0008, 16'hFFFE, 0, 0};
    tbl[10] = '{enc(2, 2, 1, 3, 0),         1, 2, 16'h0000, 1, 2, 16'hFFF6, 16'h0008, 0, 0};
    tbl[11] = '{enc(3, 3, 1, 6, 0),         1, 3, 16'hFFFF, 1, 3, 16'hFFF6, 16'h0009, 0, 0};
    tbl[12] = '{enc(0, 4, 3, 1, 1),         1, 4, 16'hFFF6, 1, 0, 16'hFFFF, 16'hFFF6, 1, 0};

    rst = 1'b1; instr_valid = 1'b0; instr = '0; resume = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero_outputs("reset");
    chk("reset_ready", 32'(instr_ready), 32'd1);

    // Main datapath: back-to-back issue with forwarding, illegal op, r0 writes.
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wb)
        push(tbl[i].a, tbl[i].d, tbl[i].alu, tbl[i].op, tbl[i].i1, tbl[i].i2,
             tbl[i].ci, tbl[i].bi);
      step(1'b1, tbl[i].w, 1'b0, 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("retire_after_table", 32'(retire_cnt), 32'd12);

    // HALT with a writeback still in stage 2 and the next instruction held.
    push(3'd2, 16'h0022, 0, 4'd0, '0, '0, 0, 0);
    step(1'b1, ldi(2, 'h22), 1'b0, 1'b0);
    step(1'b1, 16'hE000, 1'b0, 1'b0);
    repeat (5) step(1'b1, ldi(1, 'h55), 1'b0, 1'b0);
    step(1'b1, ldi(1, 'h55), 1'b1, 1'b0);
    push(3'd1, 16'h0055, 0, 4'd0, '0, '0, 0, 0);
    step(1'b1, ldi(1, 'h55), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Reset while an ADD is in stage 2.
    push(3'd3, 16'h0007, 0, 4'd0, '0, '0, 0, 0);
    step(1'b1, ldi(3, 7), 1'b0, 1'b0);
    push(3'd4, 16'h000E, 1, 4'd0, 16'h0007, 16'h0007, 0, 0);
    step(1'b1, enc(0, 4, 3, 3, 0), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    rst = 1'b0; instr_valid = 1'b0;
    #1;
    chk_zero_outputs("midrst");

    // Every register must read back zero after reset.
    for (int k = 1; k < 8; k++) begin
      push(3'd0, 16'h0000, 1, 4'd3, 16'h0000, 16'h0000, 0, 0);
      step(1'b1, enc(3, 0, k, 0, 0), 1'b0, 1'b0);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
